// File: rtl/add_sub_serial.sv
// add_sub_serial: digit-serial adder/subtractor.
// Captures WIDTH-bit operands on a start strobe and consumes DIGIT bits per
// clock, LSB first, shifting the result in from the MSB end. Subtraction is
// a + ~b + 1, so cout is NOT borrow.
// Optional: define ADD_SUB_SERIAL_OVF_EN to add the signed-overflow output ovf.
// WIDTH must be >= 2 and a multiple of DIGIT; 1 <= DIGIT <= WIDTH.
module add_sub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             busy,
`ifdef ADD_SUB_SERIAL_OVF_EN
    output logic             done,
    output logic             ovf
`else
    output logic             done
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_out;
    logic             r_cout;

    logic [DIGIT:0]   w_sum;
    logic [WIDTH-1:0] w_out_next;
    logic             w_last;

    // One digit of the ripple sum: {carry out, digit result}
    always_comb begin
        w_sum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, r_carry};
    end

    // New digit enters at the MSB end; a single-digit operation replaces all bits
    generate
        if (DIGIT == WIDTH) begin : g_full
            assign w_out_next = w_sum[DIGIT-1:0];
        end else begin : g_shift
            assign w_out_next = {w_sum[DIGIT-1:0], r_out[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign w_last = (r_count == LAST);

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_out   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub;
                        r_count <= '0;
                        r_out   <= '0;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_out   <= w_out_next;
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_sum[DIGIT];
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_cout  <= w_sum[DIGIT];
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ADD_SUB_SERIAL_OVF_EN
    logic r_ovf;
    logic w_msb_cin;

    // Carry into the result MSB recovered from the MSB sum bit: s = a ^ b ^ cin
    assign w_msb_cin = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_sum[DIGIT-1];

    // Signed overflow latched on the final digit, cleared at each start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_IDLE && en) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_ADD && w_last) begin
            r_ovf <= w_msb_cin ^ w_sum[DIGIT];
        end
    end

    assign ovf = r_ovf;
`endif

    assign out  = r_out;
    assign cout = r_cout;
    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_add_sub_serial.sv
// Bench for add_sub_serial: three instances (8/1, 8/4, 16/2) driven from a
// directed vector table, plus hand sequences for held start and mid-op reset.
module tb_add_sub_serial;

    logic        clk;
    logic        rst;
    logic        en_v  [3];
    logic        sub_v [3];
    logic [15:0] a_v   [3];
    logic [15:0] b_v   [3];

    logic [7:0]  out0, out1;
    logic [15:0] out2;
    logic        cout_v[3], busy_v[3], done_v[3];
`ifdef ADD_SUB_SERIAL_OVF_EN
    logic        ovf_v [3];
`endif
    logic [15:0] mo[3];

    int checks = 0;
    int errors = 0;

    always_comb begin
        mo[0] = {8'h00, out0};
        mo[1] = {8'h00, out1};
        mo[2] = out2;
    end

    add_sub_serial #(.WIDTH(8), .DIGIT(1)) u0 (
        .clk(clk), .rst(rst), .en(en_v[0]), .sub(sub_v[0]),
        .a(a_v[0][7:0]), .b(b_v[0][7:0]), .out(out0), .cout(cout_v[0]),
`ifdef ADD_SUB_SERIAL_OVF_EN
        .ovf(ovf_v[0]),
`endif
        .busy(busy_v[0]), .done(done_v[0]));

    add_sub_serial #(.WIDTH(8), .DIGIT(4)) u1 (
        .clk(clk), .rst(rst), .en(en_v[1]), .sub(sub_v[1]),
        .a(a_v[1][7:0]), .b(b_v[1][7:0]), .out(out1), .cout(cout_v[1]),
`ifdef ADD_SUB_SERIAL_OVF_EN
        .ovf(ovf_v[1]),
`endif
        .busy(busy_v[1]), .done(done_v[1]));

    add_sub_serial #(.WIDTH(16), .DIGIT(2)) u2 (
        .clk(clk), .rst(rst), .en(en_v[2]), .sub(sub_v[2]),
        .a(a_v[2]), .b(b_v[2]), .out(out2), .cout(cout_v[2]),
`ifdef ADD_SUB_SERIAL_OVF_EN
        .ovf(ovf_v[2]),
`endif
        .busy(busy_v[2]), .done(done_v[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          dut;
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] eo;
        logic        ec;
        int          lat;
        logic        ev;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int cyc;
        int bcnt;
        bit seen;
        @(negedge clk);
        en_v[v.dut]  = 1'b1;
        sub_v[v.dut] = v.sub;
        a_v[v.dut]   = v.a;
        b_v[v.dut]   = v.b;
        @(posedge clk); #1;
        bcnt = busy_v[v.dut] ? 1 : 0;
        cyc  = 0;
        seen = 1'b0;
        @(negedge clk);
        en_v[v.dut] = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (busy_v[v.dut]) bcnt++;
            if (done_v[v.dut]) seen = 1'b1;
        end
        chk($sformatf("v%0d done_seen", id), 32'(seen), 32'd1);
        chk($sformatf("v%0d latency", id), 32'(cyc), 32'(v.lat));
        chk($sformatf("v%0d busy_cycles", id), 32'(bcnt), 32'(v.lat + 1));
        chk($sformatf("v%0d out", id), 32'(mo[v.dut]), 32'(v.eo));
        chk($sformatf("v%0d cout", id), 32'(cout_v[v.dut]), 32'(v.ec));
`ifdef ADD_SUB_SERIAL_OVF_EN
        chk($sformatf("v%0d ovf", id), 32'(ovf_v[v.dut]), 32'(v.ev));
`endif
        @(posedge clk); #1;
        chk($sformatf("v%0d done_one_cycle", id), 32'(done_v[v.dut]), 32'd0);
        chk($sformatf("v%0d idle_after", id), 32'(busy_v[v.dut]), 32'd0);
        chk($sformatf("v%0d out_held", id), 32'(mo[v.dut]), 32'(v.eo));
    endtask

    initial begin
        int dcnt;
        //            dut sub a         b         out       cout lat ovf
        vt[0] = '{0, 1'b0, 16'h003C, 16'h005A, 16'h0096, 1'b0, 8, 1'b1};
        vt[1] = '{0, 1'b0, 16'h00FF, 16'h0001, 16'h0000, 1'b1, 8, 1'b0};
        vt[2] = '{0, 1'b1, 16'h0010, 16'h0020, 16'h00F0, 1'b0, 8, 1'b0};
        vt[3] = '{1, 1'b0, 16'h00A5, 16'h005B, 16'h0000, 1'b1, 2, 1'b0};
        vt[4] = '{2, 1'b1, 16'h1234, 16'h0234, 16'h1000, 1'b1, 8, 1'b0};
        vt[5] = '{0, 1'b1, 16'h0055, 16'h0055, 16'h0000, 1'b1, 8, 1'b0};
        vt[6] = '{0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 8, 1'b0};
        vt[7] = '{0, 1'b0, 16'h007F, 16'h0001, 16'h0080, 1'b0, 8, 1'b1};
        vt[8] = '{0, 1'b1, 16'h0080, 16'h0001, 16'h007F, 1'b1, 8, 1'b1};
        vt[9] = '{0, 1'b0, 16'h0005, 16'h0003, 16'h0008, 1'b0, 8, 1'b0};

        for (int i = 0; i < 3; i++) begin
            en_v[i] = 1'b0; sub_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset out%0d", i), 32'(mo[i]), 32'd0);
            chk($sformatf("reset cout%0d", i), 32'(cout_v[i]), 32'd0);
            chk($sformatf("reset busy%0d", i), 32'(busy_v[i]), 32'd0);
            chk($sformatf("reset done%0d", i), 32'(done_v[i]), 32'd0);
`ifdef ADD_SUB_SERIAL_OVF_EN
            chk($sformatf("reset ovf%0d", i), 32'(ovf_v[i]), 32'd0);
`endif
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vt[i], i);

        // Mid-operation reset: leave cout=1 first so the clear is visible
        run_vec(vt[1], 1);
        @(negedge clk);
        en_v[0] = 1'b1; sub_v[0] = 1'b0; a_v[0] = 16'h003C; b_v[0] = 16'h005A;
        @(posedge clk); #1;
        @(negedge clk);
        en_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst busy", 32'(busy_v[0]), 32'd0);
        chk("midrst out", 32'(mo[0]), 32'd0);
        chk("midrst cout", 32'(cout_v[0]), 32'd0);
        chk("midrst done", 32'(done_v[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done_v[0]) dcnt++;
        end
        chk("midrst no_done", 32'(dcnt), 32'd0);
        run_vec(vt[0], 100);

        // en held high across a whole operation and into the next start
        @(negedge clk);
        en_v[0] = 1'b1; sub_v[0] = 1'b0; a_v[0] = 16'h0001; b_v[0] = 16'h0002;
        @(posedge clk); #1;
        @(negedge clk);
        a_v[0] = 16'h0040; b_v[0] = 16'h0040;
        dcnt = 0;
        for (int i = 1; i <= 18; i++) begin
            @(posedge clk); #1;
            if (done_v[0]) dcnt++;
            if (i == 8) begin
                chk("held done1", 32'(done_v[0]), 32'd1);
                chk("held out1", 32'(mo[0]), 32'h03);
                chk("held cout1", 32'(cout_v[0]), 32'd0);
            end
            if (i == 9) chk("held idle_gap", 32'(busy_v[0]), 32'd0);
            if (i == 10) begin
                chk("held restart", 32'(busy_v[0]), 32'd1);
                en_v[0] = 1'b0;
            end
            if (i == 18) begin
                chk("held done2", 32'(done_v[0]), 32'd1);
                chk("held out2", 32'(mo[0]), 32'h80);
            end
        end
        chk("held done_count", 32'(dcnt), 32'd2);
        @(posedge clk); #1;
        chk("held final_idle", 32'(busy_v[0]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_sub_serial.md
Name: add_sub_serial

Overview:
- Parametrised digit-serial adder/subtractor; successor to the fixed 8-bit bit-serial adder.
- Captures two WIDTH-bit operands on a start strobe and processes DIGIT bits per clock, LSB first.
- Assembles the result in a shift register and reports carry/borrow, busy and a one-cycle done pulse.
- Used as an area-cheap arithmetic slave behind a simple start/done handshake.

Parameters:
- WIDTH, 8: operand/result width in bits; must be ≥ 2 and a multiple of DIGIT.
- DIGIT, 1: bits processed per clock; 1 ≤ DIGIT ≤ WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- en  input  1  start strobe; sampled only in IDLE
- sub  input  1  0 = a+b, 1 = a-b; sampled with en
- a  input  WIDTH  operand A; sampled with en
- b  input  WIDTH  operand B; sampled with en
- out  output  WIDTH  result register
- cout  output  1  final carry out (add) / NOT borrow (sub)
- busy  output  1  high whenever state != IDLE
- done  output  1  high for exactly one cycle when the result is valid

Behaviour:
- Decided: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset, sampled at the clock edge with `rst`=1:
  - state=IDLE.
  - out, cout, a_reg, b_reg, carry and count all 0.
  - busy=0, done=0.
  - Applies from any state, including mid-operation; a partial result is discarded and no done pulse is issued.
- Derived constant: N = WIDTH/DIGIT. count is max(1, clog2(N)) bits wide.
- States: IDLE, ADD, DONE. busy = (state!=IDLE); done = (state==DONE).
- IDLE:
  - en=0: hold everything; out and cout keep the last result.
  - en=1:
    - a_reg<=a.
    - b_reg<=(sub ? ~b : b).
    - carry<=sub.
    - count<=0, out<=0.
    - state<=ADD.
- ADD, every cycle:
  - {c,s} = a_reg[DIGIT-1:0] + b_reg[DIGIT-1:0] + carry, a (DIGIT+1)-bit sum.
  - out<={s, out[WIDTH-1:DIGIT]}, i.e. shift right by DIGIT with s entering at the MSB end.
  - a_reg<=a_reg>>DIGIT; b_reg<=b_reg>>DIGIT.
  - carry<=c; count<=count+1.
  - When count==N-1: cout<=c and state<=DONE. Otherwise stay in ADD.
- DONE:
  - Hold out and cout; state<=IDLE unconditionally.
  - en is ignored in DONE.
- Latency: the edge that samples en is edge k. done is high in the cycle after edge k+N, so N cycles start-to-done (8 for the defaults). The next start can be accepted at edge k+N+2 at the earliest.
- en is ignored while busy; sub, a and b are don't-care outside the IDLE edge that samples en.
- Arithmetic is modulo 2^WIDTH.
  - Subtract is two's complement: cout=1 means no borrow (a ≥ b unsigned).
  - Operands a=b, or either operand 0, need no special handling.

Optional Feature:
- Macro: ADD_SUB_SERIAL_OVF_EN.
- Defined:
  - Adds output port `ovf` (1 bit), reset 0.
  - On the final ADD cycle, ovf <= carry into the result MSB XOR c, the signed two's-complement overflow.
  - ovf is held with out and cleared at the next start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=8, DIGIT=1, sub=0, a=8'h3C, b=8'h5A, en pulse → busy high 9 cycles, done pulse 8 cycles after the start edge, out=8'h96, cout=0.
2. WIDTH=8, DIGIT=1, sub=0, a=8'hFF, b=8'h01 → out=8'h00, cout=1. Then sub=1, a=8'h10, b=8'h20 → out=8'hF0, cout=0 (borrow).
3. WIDTH=8, DIGIT=4, sub=0, a=8'hA5, b=8'h5B → out=8'h00, cout=1, done 2 cycles after the start edge. WIDTH=16, DIGIT=2, sub=1, a=16'h1234, b=16'h0234 → out=16'h1000, cout=1.
4. en held high continuously with new operands while busy → the running result is unaffected. The second operation starts only on the first IDLE edge with en=1. done pulses exactly once per operation.
5. rst asserted for one cycle at count=3 of an 8-cycle add → the next cycle shows state IDLE and out=0, cout=0, busy=0, no done pulse. A fresh start then completes correctly.
6. With ADD_SUB_SERIAL_OVF_EN defined, WIDTH=8:
   - a=8'h7F + b=8'h01 → out=8'h80, ovf=1.
   - sub=1, a=8'h80, b=8'h01 → out=8'h7F, ovf=1.
   - a=8'h05 + b=8'h03 → ovf=0.
